// File: rtl/pull_pkg.sv
// Shared types and sizing for the systolic-result pull controller.
// Beat count and select width derive from the array and thread counts.
package pull_pkg;

  localparam int DATA_WIDTH        = 16;
  localparam int NUM_THREADS       = 8;
  localparam int NUM_RESULTS       = 16;
  localparam int REG_ADDR_WIDTH    = 4;
  localparam int BEATS             = NUM_RESULTS / NUM_THREADS;
  localparam int BEAT_W            = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DEFAULT_MAX_STALL = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MM,
    BEAT,
    DONE
  } pull_state_e;

endpackage

// File: rtl/pull_controller_arbiter.sv
// Shares the register-file write port between ALU writeback and pull beats.
// ALU wins by default; a pull beat is forced through after MAX_STALL losses.
module rf_port_arbiter #(
  parameter int MAX_STALL = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic alu_wb_req,
  input  logic pull_req,
  output logic pull_grant,
  output logic alu_wb_grant
);

  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  logic [SW-1:0] stall_cnt_q;
  logic [SW-1:0] stall_cnt_d;

  always_comb begin
    pull_grant   = pull_req &&
                   (!alu_wb_req || stall_cnt_q == STALL_MAX);
    alu_wb_grant = alu_wb_req && !pull_grant;
    stall_cnt_d  = stall_cnt_q;
    if (clr || pull_grant) begin
      stall_cnt_d = '0;
    end else if (pull_req && stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: rtl/pull_controller.sv
// Moves the 16 array results into the thread register files in two beats,
// sharing the register-file write port with ALU writeback.
module pull_controller
  import pull_pkg::*;
#(
  parameter int MAX_STALL = DEFAULT_MAX_STALL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_pull,
  input  logic [REG_ADDR_WIDTH-1:0] pull_rd,
  input  logic                      matmul_done,
  input  logic                      alu_wb_req,
  output logic                      alu_wb_grant,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [BEAT_W-1:0]         beat_sel,
  output logic                      pull_busy,
  output logic                      pull_done,
  output logic                      matmul_consume,
  output logic                      pull_overrun
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  pull_state_e               state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [REG_ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
  logic                      start_ok;
  logic                      pull_grant;

  rf_port_arbiter #(
    .MAX_STALL (MAX_STALL)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .clr          (start_ok),
    .alu_wb_req   (alu_wb_req),
    .pull_req     (state_q == BEAT),
    .pull_grant   (pull_grant),
    .alu_wb_grant (alu_wb_grant)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rd_base_d = rd_base_q;
    start_ok  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_pull) begin
          state_d   = WAIT_MM;
          rd_base_d = pull_rd;
          beat_d    = '0;
          start_ok  = 1'b1;
        end
      end
      WAIT_MM: begin
        if (matmul_done) begin
          state_d = BEAT;
          beat_d  = '0;
        end
      end
      BEAT: begin
        if (pull_grant) begin
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      rd_base_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      rd_base_q <= rd_base_d;
    end
  end

  assign rf_we          = pull_grant;
  assign rf_waddr       = rd_base_q + REG_ADDR_WIDTH'(beat_q);
  assign beat_sel       = beat_q;
  assign pull_busy      = (state_q != IDLE);
  assign pull_done      = (state_q == DONE);
  assign matmul_consume = (state_q == DONE);
  assign pull_overrun   = start_pull && (state_q != IDLE);

endmodule

// File: tb/tb_pull_controller.sv
// Directed literal checks plus randomized traffic against a pull model.
module tb_pull_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_pull;
  logic [3:0] pull_rd;
  logic       matmul_done;
  logic       alu_wb_req;
  logic       alu_wb_grant;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [0:0] beat_sel;
  logic       pull_busy;
  logic       pull_done;
  logic       matmul_consume;
  logic       pull_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pull_controller dut (
    .clk            (clk),
    .reset          (reset),
    .start_pull     (start_pull),
    .pull_rd        (pull_rd),
    .matmul_done    (matmul_done),
    .alu_wb_req     (alu_wb_req),
    .alu_wb_grant   (alu_wb_grant),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .beat_sel       (beat_sel),
    .pull_busy      (pull_busy),
    .pull_done      (pull_done),
    .matmul_consume (matmul_consume),
    .pull_overrun   (pull_overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Pull model: a request is pending, waits for results, writes 2 beats,
  // then announces completion for one cycle.
  bit m_busy = 0;
  bit m_mm   = 0;
  int m_wr   = 0;
  int m_stl  = 0;
  int m_base = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0;
      m_mm   <= 0;
      m_wr   <= 0;
      m_stl  <= 0;
      m_base <= 0;
    end else if (!m_busy) begin
      if (start_pull) begin
        m_busy <= 1;
        m_mm   <= 0;
        m_wr   <= 0;
        m_stl  <= 0;
        m_base <= int'(pull_rd);
      end
    end else if (!m_mm) begin
      if (matmul_done) m_mm <= 1;
    end else if (m_wr < 2) begin
      if (!alu_wb_req || m_stl == 3) begin
        m_wr  <= m_wr + 1;
        m_stl <= 0;
      end else if (m_stl < 3) begin
        m_stl <= m_stl + 1;
      end
    end else begin
      m_busy <= 0;
    end
  end

  always @(negedge clk) begin
    bit in_beat, win, e_done;
    int e_addr, e_sel;
    in_beat = 0;
    win     = 0;
    e_done  = 0;
    e_addr  = 0;
    e_sel   = 0;
    if (!reset) begin
      in_beat = m_busy && m_mm && m_wr < 2;
      win     = in_beat && (!alu_wb_req || m_stl == 3);
      e_done  = m_busy && m_wr == 2;
      e_sel   = in_beat ? m_wr : 0;
      e_addr  = (m_base + e_sel) % 16;
    end
    chk("m_rf_we", rf_we, win);
    if (win) chk("m_rf_waddr", rf_waddr, e_addr);
    chk("m_beat_sel", beat_sel, e_sel);
    chk("m_alu_grant", alu_wb_grant, alu_wb_req && !win);
    chk("m_busy", pull_busy, !reset && m_busy);
    chk("m_done", pull_done, e_done);
    chk("m_consume", matmul_consume, e_done);
    chk("m_overrun", pull_overrun, !reset && m_busy && start_pull);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; start_pull = 0; pull_rd = 0;
    matmul_done = 0; alu_wb_req = 0;
    cyc(); cyc();
    alu_wb_req = 1;
    neg();
    chk("rst_we", rf_we, 0);
    chk("rst_busy", pull_busy, 0);
    chk("rst_grant", alu_wb_grant, 1);
    chk("rst_sel", beat_sel, 0);
    cyc();
    reset = 0; alu_wb_req = 0;
    cyc();

    // basic pull
    start_pull = 1; pull_rd = 4; matmul_done = 1;
    neg(); chk("basic_ovr0", pull_overrun, 0);
    cyc(); start_pull = 0; pull_rd = 0;
    neg(); chk("basic_c1_we", rf_we, 0); chk("basic_c1_busy", pull_busy, 1);
    cyc();
    neg(); chk("basic_c2_we", rf_we, 1); chk("basic_c2_addr", rf_waddr, 4);
    chk("basic_c2_sel", beat_sel, 0);
    cyc();
    neg(); chk("basic_c3_we", rf_we, 1); chk("basic_c3_addr", rf_waddr, 5);
    chk("basic_c3_sel", beat_sel, 1);
    cyc();
    neg(); chk("basic_c4_done", pull_done, 1);
    chk("basic_c4_cons", matmul_consume, 1); chk("basic_c4_we", rf_we, 0);
    cyc();
    neg(); chk("basic_c5_busy", pull_busy, 0);

    // wait for matmul
    start_pull = 1; pull_rd = 0; matmul_done = 0;
    cyc(); start_pull = 0;
    for (int k = 1; k <= 5; k++) begin
      neg(); chk("wait_no_we", rf_we, 0);
      cyc();
    end
    matmul_done = 1;
    neg(); chk("wait_c6_we", rf_we, 0);
    cyc();
    neg(); chk("wait_c7_we", rf_we, 1); chk("wait_c7_addr", rf_waddr, 0);
    cyc();
    neg(); chk("wait_c8_we", rf_we, 1); chk("wait_c8_addr", rf_waddr, 1);
    cyc();
    neg(); chk("wait_c9_done", pull_done, 1);
    matmul_done = 0;
    cyc();

    // contention and starvation
    start_pull = 1; pull_rd = 2; matmul_done = 1; alu_wb_req = 1;
    cyc(); start_pull = 0;
    cyc();
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 3; s++) begin
        neg(); chk("cont_stall_we", rf_we, 0);
        chk("cont_stall_grant", alu_wb_grant, 1);
        cyc();
      end
      neg(); chk("cont_win_we", rf_we, 1);
      chk("cont_win_grant", alu_wb_grant, 0);
      chk("cont_win_addr", rf_waddr, 2 + b);
      chk("cont_win_sel", beat_sel, b);
      cyc();
    end
    neg(); chk("cont_done", pull_done, 1); chk("cont_done_grant", alu_wb_grant, 1);
    cyc(); alu_wb_req = 0;

    // wrap-around
    start_pull = 1; pull_rd = 15;
    cyc(); start_pull = 0;
    cyc();
    neg(); chk("wrap_addr0", rf_waddr, 15); chk("wrap_we0", rf_we, 1);
    cyc();
    neg(); chk("wrap_addr1", rf_waddr, 0); chk("wrap_we1", rf_we, 1);
    cyc();
    neg(); chk("wrap_done", pull_done, 1);
    cyc();

    // overrun during WAIT_MM
    start_pull = 1; pull_rd = 3; matmul_done = 0;
    cyc(); pull_rd = 9;
    neg(); chk("ovr_pulse", pull_overrun, 1);
    cyc(); start_pull = 0; matmul_done = 1;
    neg(); chk("ovr_clear", pull_overrun, 0); chk("ovr_c2_we", rf_we, 0);
    cyc();
    neg(); chk("ovr_addr0", rf_waddr, 3); chk("ovr_we0", rf_we, 1);
    cyc();
    neg(); chk("ovr_addr1", rf_waddr, 4);
    cyc();
    neg(); chk("ovr_done", pull_done, 1);
    cyc();
    neg(); chk("ovr_single_done", pull_done, 0); chk("ovr_idle", pull_busy, 0);

    // reset mid-BEAT
    start_pull = 1; pull_rd = 6;
    cyc(); start_pull = 0;
    cyc();
    neg(); chk("rstm_addr0", rf_waddr, 6); chk("rstm_we0", rf_we, 1);
    cyc(); reset = 1;
    neg(); chk("rstm_we", rf_we, 0); chk("rstm_busy", pull_busy, 0);
    chk("rstm_done", pull_done, 0);
    cyc(); reset = 0;
    neg(); chk("rstm_after_we", rf_we, 0); chk("rstm_after_done", pull_done, 0);
    cyc();
    start_pull = 1; pull_rd = 7;
    cyc(); start_pull = 0;
    cyc();
    neg(); chk("fresh_addr0", rf_waddr, 7); chk("fresh_we0", rf_we, 1);
    cyc();
    neg(); chk("fresh_addr1", rf_waddr, 8);
    cyc();
    neg(); chk("fresh_done", pull_done, 1);
    cyc();

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      start_pull = ($urandom_range(0, 5) == 0);
      pull_rd    = 4'($urandom);
      if ($urandom_range(0, 3) == 0) matmul_done = ~matmul_done;
      alu_wb_req = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 0; start_pull = 0;
    repeat (10) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
